// File: rtl/audio_stream_ctrl.sv
// CODEC sample-pair sequencer: ADC pop -> optional processing stage -> DAC push, with drop/sample stats.
// Optional build macro AUDIO_STREAM_MUTE_EN adds a mute input that zeroes data loaded into writedata_*.
`timescale 1ns/1ps
module audio_stream_ctrl #(
    parameter int DATA_W         = 24,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
`ifdef AUDIO_STREAM_MUTE_EN
    input  logic              mute,
`endif
    input  logic              bypass,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              write,
    output logic              proc_out_valid,
    input  logic              proc_out_ready,
    output logic [DATA_W-1:0] proc_out_left,
    output logic [DATA_W-1:0] proc_out_right,
    input  logic              proc_in_valid,
    input  logic [DATA_W-1:0] proc_in_left,
    input  logic [DATA_W-1:0] proc_in_right,
    output logic              proc_in_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  drop_count
);

    // state     | meaning
    // RD_WAIT   | idle, waiting for an ADC sample pair
    // RD_ACK    | pop pulse to CODEC, bypass decision
    // PROC_SEND | offering pair to the processing stage
    // PROC_WAIT | waiting for processed pair (timed)
    // WR_WAIT   | waiting for DAC FIFO space (timed)
    // WR_ACK    | push pulse to CODEC, count sample
    typedef enum logic [2:0] {
        S_RD_WAIT,
        S_RD_ACK,
        S_PROC_SEND,
        S_PROC_WAIT,
        S_WR_WAIT,
        S_WR_ACK
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DATA_W-1:0]   r_hold_l;
    logic [DATA_W-1:0]   r_hold_r;
    logic [DATA_W-1:0]   r_wd_l;
    logic [DATA_W-1:0]   r_wd_r;
    logic                r_read;
    logic                r_write;
    logic                r_pov;
    logic                r_pir;
    logic                r_busy;
    logic [CNT_W-1:0]    r_samples;
    logic [CNT_W-1:0]    r_drops;
    logic                w_mute;
    logic                w_expired;

`ifdef AUDIO_STREAM_MUTE_EN
    assign w_mute = mute;
`else
    assign w_mute = 1'b0;
`endif

    assign w_expired = (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state    <= S_RD_WAIT;
            r_wait_cnt <= '0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_wd_l     <= '0;
            r_wd_r     <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_pov      <= 1'b0;
            r_pir      <= 1'b0;
            r_busy     <= 1'b0;
            r_samples  <= '0;
            r_drops    <= '0;
        end else begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            case (r_state)
                S_RD_WAIT: begin
                    if (read_ready) begin
                        r_hold_l <= readdata_left;
                        r_hold_r <= readdata_right;
                        r_read   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_RD_ACK;
                    end
                end
                S_RD_ACK: begin
                    if (bypass) begin
                        r_wd_l     <= w_mute ? '0 : r_hold_l;
                        r_wd_r     <= w_mute ? '0 : r_hold_r;
                        r_wait_cnt <= '0;
                        r_state    <= S_WR_WAIT;
                    end else begin
                        r_pov   <= 1'b1;
                        r_state <= S_PROC_SEND;
                    end
                end
                S_PROC_SEND: begin
                    if (proc_out_ready) begin
                        r_pov      <= 1'b0;
                        r_pir      <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= S_PROC_WAIT;
                    end
                end
                S_PROC_WAIT: begin
                    // a late response on the expiry cycle still completes the sample
                    if (proc_in_valid) begin
                        r_wd_l     <= w_mute ? '0 : proc_in_left;
                        r_wd_r     <= w_mute ? '0 : proc_in_right;
                        r_pir      <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WR_WAIT;
                    end else if (w_expired) begin
                        r_pir   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_RD_WAIT;
                        if (r_drops != '1) r_drops <= r_drops + 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (write_ready) begin
                        r_write <= 1'b1;
                        r_state <= S_WR_ACK;
                    end else if (w_expired) begin
                        r_busy  <= 1'b0;
                        r_state <= S_RD_WAIT;
                        if (r_drops != '1) r_drops <= r_drops + 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_WR_ACK: begin
                    r_samples <= r_samples + 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_RD_WAIT;
                end
                default: begin
                    r_pov   <= 1'b0;
                    r_pir   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_RD_WAIT;
                end
            endcase
        end
    end

    assign read            = r_read;
    assign write           = r_write;
    assign writedata_left  = r_wd_l;
    assign writedata_right = r_wd_r;
    assign proc_out_valid  = r_pov;
    assign proc_out_left   = r_hold_l;
    assign proc_out_right  = r_hold_r;
    assign proc_in_ready   = r_pir;
    assign busy            = r_busy;
    assign sample_count    = r_samples;
    assign drop_count      = r_drops;

endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
- Sequences the audio CODEC read/write handshake: pops one stereo sample pair from the ADC side and routes it through an external processing stage over a valid/ready interface (or bypasses that stage).
- Pushes the result to the DAC side and tracks sample and drop statistics.
- Sits between the audio_codec instance and the filter/effects datapath in the top-level audio designs, replacing ad-hoc per-lab copy logic.

Parameters:
- DATA_W, 24, sample width per channel
- TIMEOUT_CYCLES, 4096, max cycles waiting in PROC_WAIT or WR_WAIT before the sample is dropped
- CNT_W, 16, width of sample_count and drop_count

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- bypass  in  1  1 = skip processing stage; sampled in RD_ACK
- read_ready  in  1  CODEC ADC FIFO holds a sample pair
- readdata_left  in  DATA_W  ADC left sample at FIFO head
- readdata_right  in  DATA_W  ADC right sample at FIFO head
- read  out  1  one-cycle pop pulse to CODEC
- write_ready  in  1  CODEC DAC FIFO has space
- writedata_left  out  DATA_W  DAC left sample, registered
- writedata_right  out  DATA_W  DAC right sample, registered
- write  out  1  one-cycle push pulse to CODEC
- proc_out_valid  out  1  sample pair offered to processing stage
- proc_out_ready  in  1  processing stage accepts
- proc_out_left  out  DATA_W  left sample to stage
- proc_out_right  out  DATA_W  right sample to stage
- proc_in_valid  in  1  processed pair returned
- proc_in_left  in  DATA_W  processed left sample
- proc_in_right  in  DATA_W  processed right sample
- proc_in_ready  out  1  high only in PROC_WAIT
- busy  out  1  state != RD_WAIT
- sample_count  out  CNT_W  completed writes, wraps modulo 2^CNT_W
- drop_count  out  CNT_W  timed-out samples, saturates at all-ones

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=RD_WAIT.
  - All outputs 0, including read, write, proc_out_valid, data registers and counters.
  - Reset mid-operation discards any held sample; no read/write pulse is emitted on the reset cycle.
- FSM states: RD_WAIT, RD_ACK, PROC_SEND, PROC_WAIT, WR_WAIT, WR_ACK.
- RD_WAIT:
  - If read_ready=1, latch readdata_left/right into the hold registers; go to RD_ACK.
- RD_ACK:
  - read=1 for exactly this cycle.
  - If bypass=1, copy the hold registers to writedata_* and go to WR_WAIT; else go to PROC_SEND.
- PROC_SEND:
  - proc_out_valid=1 and proc_out_* = hold registers, held stable until proc_out_ready=1.
  - On valid&ready, go to PROC_WAIT.
  - No timeout in this state.
- PROC_WAIT:
  - proc_in_ready=1.
  - On proc_in_valid=1, latch proc_in_* into writedata_*; go to WR_WAIT.
- WR_WAIT:
  - If write_ready=1, go to WR_ACK.
- WR_ACK:
  - write=1 for exactly this cycle; writedata_* are stable.
  - sample_count increments (wraps); go to RD_WAIT.
- Timeout:
  - A wait counter clears on entry to PROC_WAIT or WR_WAIT and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, go to RD_WAIT, drop the sample and increment drop_count (saturating).
  - If the exit condition and expiry coincide, the exit condition wins; no drop.
- Latency, bypass, both CODEC sides ready: read_ready seen at cycle 0 → read at cycle 1 → write at cycle 3.
- read and write are never high in the same cycle; at most one sample pair is in flight.
- bypass changes outside RD_ACK have no effect on the current sample.

Optional Feature:
- Macro AUDIO_STREAM_MUTE_EN.
- When defined, adds input port mute (1 bit). If mute=1 in the cycle a value is loaded into writedata_*, zeros are loaded instead; handshakes and counters are unchanged.
- When undefined, the port does not exist and data passes unmodified.

Test Plan:
- Bypass=1, read_ready=1 with L=24'h123456 / R=24'hABCDEF, write_ready=1 → read pulses cycle 1, write pulses cycle 3 with the same data, sample_count=1.
- Bypass=0, stage returns L+1 one cycle after accept, proc_out_ready held 0 for 3 cycles → proc_out_valid/data stable for 3 cycles, write carries 24'h123457, exactly one read and one write pulse.
- Bypass=0, proc_in_valid never asserted, TIMEOUT_CYCLES=8 → return to RD_WAIT after 8 PROC_WAIT cycles, drop_count=1, no write pulse.
- write_ready held 0 then asserted on the same cycle as timeout expiry → write issued, drop_count unchanged.
- reset_n=0 while in PROC_SEND → next cycle all outputs 0, state RD_WAIT; then a normal transfer completes with sample_count=1.
- With CNT_W=4, force 20 timeouts → drop_count saturates at 4'hF; 17 transfers → sample_count wraps to 1.
